// File: rtl/riscv_apu_pkg.sv
// Shared types and constants for the APU write-back path.
package riscv_apu_pkg;

  localparam int unsigned REGADDR_W    = 6;
  localparam int unsigned APU_NUSFLAGS = 5;
  localparam int unsigned APU_DATA_W   = 32;
  localparam int unsigned APU_NREADS   = 3;

  typedef struct packed {
    logic [REGADDR_W-1:0]    waddr;
    logic [APU_DATA_W-1:0]   data;
    logic [APU_NUSFLAGS-1:0] flags;
  } apu_wb_entry_t;

  // Extract one source register from the flattened ID-stage read list.
  function automatic logic [REGADDR_W-1:0] read_reg(
    input logic [APU_NREADS*REGADDR_W-1:0] regs,
    input int unsigned                     idx
  );
    return regs[idx*REGADDR_W +: REGADDR_W];
  endfunction

endpackage

// File: rtl/riscv_apu_wb_fifo.sv
// In-order result store: circular pointers, count, per-entry valid and
// destination address exposed for dependency checking.
module riscv_apu_wb_fifo
  import riscv_apu_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned PAYLOAD_W = 37
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [REGADDR_W-1:0]       push_addr_i,
  input  logic [PAYLOAD_W-1:0]       push_data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [REGADDR_W-1:0]       head_addr_o,
  output logic [PAYLOAD_W-1:0]       head_data_o,
  output logic [DEPTH-1:0]           entry_valid_o,
  output logic [DEPTH*REGADDR_W-1:0] entry_addr_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [REGADDR_W-1:0] r_addr [DEPTH];
  logic [PAYLOAD_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]     r_valid;
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;

  // Explicit wrap so non-power-of-2 depths stay in range.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (pop_i) begin
        r_rptr          <= next_ptr(r_rptr);
        r_valid[r_rptr] <= 1'b0;
      end
      if (push_i) begin
        r_wptr          <= next_ptr(r_wptr);
        r_valid[r_wptr] <= 1'b1;
      end
      if (push_i && !pop_i) begin
        r_count <= r_count + CNT_W'(1);
      end else if (pop_i && !push_i) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_addr[r_wptr] <= push_addr_i;
      r_data[r_wptr] <= push_data_i;
    end
  end

  assign full_o        = (r_count == CNT_W'(DEPTH));
  assign empty_o       = (r_count == '0);
  assign head_addr_o   = r_addr[r_rptr];
  assign head_data_o   = r_data[r_rptr];
  assign entry_valid_o = r_valid;

  for (genvar g = 0; g < DEPTH; g++) begin : g_addr
    assign entry_addr_o[g*REGADDR_W +: REGADDR_W] = r_addr[g];
  end

endmodule

// File: rtl/riscv_apu_wb_buffer.sv
// APU result write-back buffer onto shared regfile port B, with bypass and
// RAW dependency export. Optional macro APU_WB_PERF_EN adds stall perf outputs.
module riscv_apu_wb_buffer
  import riscv_apu_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned DATA_W  = APU_DATA_W,
  parameter int unsigned FLAGS_W = APU_NUSFLAGS
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             apu_valid_i,
  output logic                             apu_ready_o,
  input  logic [DATA_W-1:0]                apu_result_i,
  input  logic [FLAGS_W-1:0]               apu_flags_i,
  input  logic [REGADDR_W-1:0]             apu_waddr_i,
  input  logic                             wb_port_busy_i,
  output logic                             regfile_we_o,
  output logic [REGADDR_W-1:0]             regfile_waddr_o,
  output logic [DATA_W-1:0]                regfile_wdata_o,
  output logic                             fflags_we_o,
  output logic [FLAGS_W-1:0]               fflags_o,
  input  logic [APU_NREADS*REGADDR_W-1:0]  read_regs_i,
  input  logic [APU_NREADS-1:0]            read_regs_valid_i,
  output logic                             read_dep_o,
  output logic                             empty_o
`ifdef APU_WB_PERF_EN
  ,
  output logic                             perf_wb_stall_o,
  output logic [15:0]                      perf_wb_cnt_o
`endif
);

  localparam int unsigned PAYLOAD_W = DATA_W + FLAGS_W;

  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_bypass;
  logic                       w_dep;
  logic [REGADDR_W-1:0]       w_head_addr;
  logic [PAYLOAD_W-1:0]       w_head_data;
  logic [DEPTH-1:0]           w_entry_valid;
  logic [DEPTH*REGADDR_W-1:0] w_entry_addr;

  // Ready depends on stored count only, never on this cycle's port state.
  assign apu_ready_o = !w_full;
  assign empty_o     = w_empty;
  assign w_bypass    = w_empty && apu_valid_i && !wb_port_busy_i;
  assign w_pop       = !w_empty && !wb_port_busy_i;
  assign w_push      = apu_valid_i && apu_ready_o && !w_bypass;

  riscv_apu_wb_fifo #(
    .DEPTH     (DEPTH),
    .PAYLOAD_W (PAYLOAD_W)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (w_push),
    .push_addr_i   (apu_waddr_i),
    .push_data_i   ({apu_result_i, apu_flags_i}),
    .pop_i         (w_pop),
    .full_o        (w_full),
    .empty_o       (w_empty),
    .head_addr_o   (w_head_addr),
    .head_data_o   (w_head_data),
    .entry_valid_o (w_entry_valid),
    .entry_addr_o  (w_entry_addr)
  );

  // Port B mux: buffered head has priority, bypass only when buffer is empty.
  always_comb begin
    regfile_we_o    = 1'b0;
    regfile_waddr_o = '0;
    regfile_wdata_o = '0;
    fflags_we_o     = 1'b0;
    fflags_o        = '0;
    if (w_pop) begin
      regfile_we_o    = 1'b1;
      regfile_waddr_o = w_head_addr;
      regfile_wdata_o = w_head_data[PAYLOAD_W-1:FLAGS_W];
      fflags_we_o     = 1'b1;
      fflags_o        = w_head_data[FLAGS_W-1:0];
    end else if (w_bypass) begin
      regfile_we_o    = 1'b1;
      regfile_waddr_o = apu_waddr_i;
      regfile_wdata_o = apu_result_i;
      fflags_we_o     = 1'b1;
      fflags_o        = apu_flags_i;
    end
  end

  // The head being written still blocks readers: no regfile write-through.
  always_comb begin
    w_dep = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < APU_NREADS; j++) begin
        if (w_entry_valid[i] && read_regs_valid_i[j] &&
            (read_reg(read_regs_i, j) == w_entry_addr[i*REGADDR_W +: REGADDR_W])) begin
          w_dep = 1'b1;
        end
      end
    end
  end

  assign read_dep_o = w_dep;

`ifdef APU_WB_PERF_EN
  logic [15:0] r_perf_cnt;

  assign perf_wb_stall_o = !w_empty && wb_port_busy_i;
  assign perf_wb_cnt_o   = r_perf_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_cnt <= '0;
    end else if (perf_wb_stall_o && (r_perf_cnt != 16'hFFFF)) begin
      r_perf_cnt <= r_perf_cnt + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_valid_when_not_ready: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(apu_valid_i && !apu_ready_o)
  ) else $error("apu_valid_i asserted while apu_ready_o=0; result dropped");
`endif

endmodule

// File: tb/tb_riscv_apu_wb_buffer.sv
// Self-checking bench for riscv_apu_wb_buffer: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_riscv_apu_wb_buffer;
  import riscv_apu_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        apu_valid_i;
  logic        apu_ready_o;
  logic [31:0] apu_result_i;
  logic [4:0]  apu_flags_i;
  logic [5:0]  apu_waddr_i;
  logic        wb_port_busy_i;
  logic        regfile_we_o;
  logic [5:0]  regfile_waddr_o;
  logic [31:0] regfile_wdata_o;
  logic        fflags_we_o;
  logic [4:0]  fflags_o;
  logic [17:0] read_regs_i;
  logic [2:0]  read_regs_valid_i;
  logic        read_dep_o;
  logic        empty_o;

  int n_vec = 0;
  int n_err = 0;

  apu_wb_entry_t q[$];
  logic        exp_ready, exp_empty, exp_we, exp_dep, exp_pop, exp_push;
  logic [5:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic [4:0]  exp_flags;
  logic [47:0] obs_vec, exp_vec;

  riscv_apu_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .apu_valid_i       (apu_valid_i),
    .apu_ready_o       (apu_ready_o),
    .apu_result_i      (apu_result_i),
    .apu_flags_i       (apu_flags_i),
    .apu_waddr_i       (apu_waddr_i),
    .wb_port_busy_i    (wb_port_busy_i),
    .regfile_we_o      (regfile_we_o),
    .regfile_waddr_o   (regfile_waddr_o),
    .regfile_wdata_o   (regfile_wdata_o),
    .fflags_we_o       (fflags_we_o),
    .fflags_o          (fflags_o),
    .read_regs_i       (read_regs_i),
    .read_regs_valid_i (read_regs_valid_i),
    .read_dep_o        (read_dep_o),
    .empty_o           (empty_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: what port B and the ID stage should see right now.
  task automatic model_eval();
    apu_wb_entry_t e;
    logic bypass;
    exp_ready = (q.size() < DEPTH);
    exp_empty = (q.size() == 0);
    exp_pop   = (q.size() > 0) && !wb_port_busy_i;
    bypass    = (q.size() == 0) && apu_valid_i && !wb_port_busy_i;
    exp_push  = apu_valid_i && exp_ready && !bypass;
    e = '0;
    if (exp_pop) e = q[0];
    else if (bypass) e = '{waddr: apu_waddr_i, data: apu_result_i, flags: apu_flags_i};
    exp_we    = exp_pop || bypass;
    exp_waddr = e.waddr;
    exp_wdata = e.data;
    exp_flags = e.flags;
    exp_dep   = 1'b0;
    foreach (q[k]) begin
      for (int j = 0; j < 3; j++) begin
        if (read_regs_valid_i[j] && (read_regs_i[j*6 +: 6] == q[k].waddr)) exp_dep = 1'b1;
      end
    end
    exp_vec = {exp_ready, exp_empty, exp_we, exp_waddr, exp_wdata, exp_we, exp_flags, exp_dep};
    obs_vec = {apu_ready_o, empty_o, regfile_we_o, regfile_waddr_o, regfile_wdata_o,
               fflags_we_o, fflags_o, read_dep_o};
  endtask

  task automatic apply(input logic v, input logic [5:0] a, input logic [31:0] d,
                       input logic [4:0] f, input logic b,
                       input logic [17:0] rr, input logic [2:0] rv);
    @(negedge clk_i);
    apu_valid_i       = v;
    apu_waddr_i       = a;
    apu_result_i      = d;
    apu_flags_i       = f;
    wb_port_busy_i    = b;
    read_regs_i       = rr;
    read_regs_valid_i = rv;
    #1;
    model_eval();
  endtask

  task automatic commit();
    if (exp_pop) void'(q.pop_front());
    if (exp_push) q.push_back('{waddr: apu_waddr_i, data: apu_result_i, flags: apu_flags_i});
  endtask

  task automatic test_reset();
    apu_valid_i = 0; apu_waddr_i = 0; apu_result_i = 0; apu_flags_i = 0;
    wb_port_busy_i = 0; read_regs_i = 0; read_regs_valid_i = 0;
    rst_ni = 0;
    #2;
    n_vec++;
    if ({apu_ready_o, empty_o, regfile_we_o, regfile_waddr_o, regfile_wdata_o, fflags_we_o,
         fflags_o, read_dep_o} !== {1'b1, 1'b1, 46'd0}) begin
      n_err++;
      $display("FAIL reset_state: got ready=%b empty=%b we=%b dep=%b want 1 1 0 0",
               apu_ready_o, empty_o, regfile_we_o, read_dep_o);
    end
    @(negedge clk_i);
    rst_ni = 1;
    q.delete();
  endtask

  task automatic test_bypass();
    apply(1, 6'd7, 32'hDEADBEEF, 5'h03, 0, '0, '0);
    n_vec++;
    if (obs_vec !== exp_vec) begin n_err++; $display("FAIL bypass: got %h want %h", obs_vec, exp_vec); end
    n_vec++;
    if ({regfile_we_o, regfile_waddr_o, regfile_wdata_o, empty_o} !== {1'b1, 6'd7, 32'hDEADBEEF, 1'b1}) begin
      n_err++;
      $display("FAIL bypass_const: got we=%b a=%0d d=%h empty=%b want 1 7 deadbeef 1",
               regfile_we_o, regfile_waddr_o, regfile_wdata_o, empty_o);
    end
    commit();
    apply(0, 0, 0, 0, 0, '0, '0);
    n_vec++;
    if (obs_vec !== exp_vec) begin n_err++; $display("FAIL bypass_idle: got %h want %h", obs_vec, exp_vec); end
    commit();
  endtask

  task automatic test_buffer_drain();
    apply(1, 6'd3, 32'h0000_0303, 5'h01, 1, '0, '0);
    n_vec++;
    if (obs_vec !== exp_vec) begin n_err++; $display("FAIL drain_push3: got %h want %h", obs_vec, exp_vec); end
    commit();
    apply(1, 6'd4, 32'h0000_0404, 5'h02, 1, '0, '0);
    commit();
    apply(0, 0, 0, 0, 1, '0, '0);
    n_vec++;
    if (obs_vec !== exp_vec || apu_ready_o !== 1'b0) begin
      n_err++; $display("FAIL drain_full: got %h want %h (ready must be 0)", obs_vec, exp_vec);
    end
    commit();
    apply(0, 0, 0, 0, 0, '0, '0);
    n_vec++;
    if (obs_vec !== exp_vec || regfile_waddr_o !== 6'd3) begin
      n_err++; $display("FAIL drain_r3: got %h want %h", obs_vec, exp_vec);
    end
    commit();
    apply(0, 0, 0, 0, 0, '0, '0);
    n_vec++;
    if (obs_vec !== exp_vec || regfile_waddr_o !== 6'd4 || apu_ready_o !== 1'b1) begin
      n_err++; $display("FAIL drain_r4: got %h want %h", obs_vec, exp_vec);
    end
    commit();
  endtask

  task automatic test_ordering();
    apply(1, 6'd5, 32'h5555_0005, 5'h05, 1, '0, '0);
    commit();
    apply(1, 6'd6, 32'h6666_0006, 5'h06, 0, '0, '0);
    n_vec++;
    if (obs_vec !== exp_vec || regfile_waddr_o !== 6'd5) begin
      n_err++; $display("FAIL order_r5: got %h want %h", obs_vec, exp_vec);
    end
    commit();
    apply(0, 0, 0, 0, 0, '0, '0);
    n_vec++;
    if (obs_vec !== exp_vec || regfile_waddr_o !== 6'd6 || regfile_wdata_o !== 32'h6666_0006) begin
      n_err++; $display("FAIL order_r6: got %h want %h", obs_vec, exp_vec);
    end
    commit();
  endtask

  task automatic test_dependency();
    apply(1, 6'd9, 32'h9, 5'h09, 1, '0, '0);
    commit();
    apply(0, 0, 0, 0, 1, {6'd0, 6'd9, 6'd0}, 3'b010);
    n_vec++;
    if (obs_vec !== exp_vec || read_dep_o !== 1'b1) begin
      n_err++; $display("FAIL dep_hit: got %h want %h", obs_vec, exp_vec);
    end
    commit();
    apply(0, 0, 0, 0, 1, {6'd0, 6'd9, 6'd0}, 3'b000);
    n_vec++;
    if (obs_vec !== exp_vec || read_dep_o !== 1'b0) begin
      n_err++; $display("FAIL dep_masked: got %h want %h", obs_vec, exp_vec);
    end
    commit();
    apply(0, 0, 0, 0, 0, {6'd0, 6'd9, 6'd0}, 3'b010);
    n_vec++;
    if (obs_vec !== exp_vec || read_dep_o !== 1'b1) begin
      n_err++; $display("FAIL dep_head_writing: got %h want %h", obs_vec, exp_vec);
    end
    commit();
    apply(1, 6'd9, 32'h99, 5'h00, 0, {6'd0, 6'd9, 6'd0}, 3'b010);
    n_vec++;
    if (obs_vec !== exp_vec || read_dep_o !== 1'b0) begin
      n_err++; $display("FAIL dep_bypass: got %h want %h", obs_vec, exp_vec);
    end
    commit();
  endtask

  task automatic test_full();
    apply(1, 6'd10, 32'hA, 5'h0A, 1, '0, '0);
    commit();
    apply(1, 6'd11, 32'hB, 5'h0B, 1, '0, '0);
    commit();
    apply(0, 0, 0, 0, 0, '0, '0);
    n_vec++;
    if (obs_vec !== exp_vec || apu_ready_o !== 1'b0 || regfile_waddr_o !== 6'd10) begin
      n_err++; $display("FAIL full_deq: got %h want %h", obs_vec, exp_vec);
    end
    commit();
    apply(1, 6'd12, 32'hC, 5'h0C, 0, '0, '0);
    n_vec++;
    if (obs_vec !== exp_vec || apu_ready_o !== 1'b1 || regfile_waddr_o !== 6'd11) begin
      n_err++; $display("FAIL full_accept: got %h want %h", obs_vec, exp_vec);
    end
    commit();
    apply(0, 0, 0, 0, 0, '0, '0);
    n_vec++;
    if (obs_vec !== exp_vec || regfile_waddr_o !== 6'd12) begin
      n_err++; $display("FAIL full_tail: got %h want %h", obs_vec, exp_vec);
    end
    commit();
  endtask

  task automatic test_reset_mid();
    apply(1, 6'd20, 32'h14, 5'h01, 1, '0, '0);
    commit();
    apply(1, 6'd21, 32'h15, 5'h02, 1, '0, '0);
    commit();
    apply(0, 0, 0, 0, 0, '0, '0);
    n_vec++;
    if (obs_vec !== exp_vec) begin n_err++; $display("FAIL rst_pre: got %h want %h", obs_vec, exp_vec); end
    #1 rst_ni = 0;
    #1;
    q.delete();
    model_eval();
    n_vec++;
    if (obs_vec !== exp_vec || regfile_we_o !== 1'b0 || empty_o !== 1'b1) begin
      n_err++; $display("FAIL rst_async: got %h want %h", obs_vec, exp_vec);
    end
    @(negedge clk_i);
    rst_ni = 1;
    for (int c = 0; c < 3; c++) begin
      apply(0, 0, 0, 0, 0, '0, '0);
      n_vec++;
      if (obs_vec !== exp_vec || regfile_we_o !== 1'b0) begin
        n_err++; $display("FAIL rst_no_stale: got %h want %h", obs_vec, exp_vec);
      end
      commit();
    end
  endtask

  task automatic test_random();
    logic        v, b;
    logic [5:0]  a;
    logic [17:0] rr;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 3) != 0) && (q.size() < DEPTH);
      b = ($urandom_range(0, 2) == 0);
      a = 6'($urandom_range(0, 63));
      rr = 18'($urandom);
      if (q.size() > 0 && $urandom_range(0, 1) == 1)
        rr[6*$urandom_range(0, 2) +: 6] = q[$urandom_range(0, q.size() - 1)].waddr;
      apply(v, a, $urandom, 5'($urandom), b, rr, 3'($urandom));
      n_vec++;
      if (obs_vec !== exp_vec) begin
        n_err++; $display("FAIL random_c%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      commit();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_buffer_drain();
    test_ordering();
    test_dependency();
    test_full();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
